alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Decode/issue stage directly upstream of alu_32. Accepts one MIPS instruction plus its register
//  operands per handshake, decodes ALU control, builds operand B (reg or extended immediate) and
//  holds the result in an ID/EX register that alu_32 samples. Single-entry valid/ready pipeline
//  register with stall and flush; unsupported opcodes are flagged, never issued as writes.
// PARAMETERS
//  CONTROL_AND  4'h0  alu_32 AND code;   CONTROL_OR  4'h1  OR;   CONTROL_ADD 4'h2  signed ADD
//  CONTROL_ADDU 4'h3  unsigned ADD;  CONTROL_SUB 4'h6  signed SUB;  CONTROL_SLT 4'h7  SLT
//  CONTROL_SUBU 4'h8  unsigned SUB;  CONTROL_NOR 4'hC  NOR
//  ENABLE_LUI   1     1: decode LUI (opcode 0x0F); 0: LUI treated as unsupported
// PORTS
//  clock          in   1   rising-edge clock, single domain
//  reset          in   1   synchronous, active-high
//  flush          in   1   discard held and incoming instruction (branch/exception redirect)
//  in_valid       in   1   instruction/rs_data/rt_data valid
//  in_ready       out  1   stage can accept this cycle
//  instruction    in   32  raw MIPS instruction word
//  rs_data        in   32  register-file value of rs
//  rt_data        in   32  register-file value of rt
//  out_valid      out  1   issued operation valid toward alu_32
//  out_ready      in   1   downstream accepts issued operation this cycle
//  input_a        out  32  ALU operand A
//  input_b        out  32  ALU operand B
//  control        out  4   ALU control code
//  dest_reg       out  5   destination register number
//  reg_write      out  1   issued op writes dest_reg
//  err_unsupported out 1   issued op was not a supported ALU instruction
// BEHAVIOUR
//  - Reset: out_valid=0, input_a=0, input_b=0, control=0, dest_reg=0, reg_write=0,
//    err_unsupported=0. Reset dominates flush and handshakes.
//  - in_ready = !out_valid || out_ready (combinational; no bubble under continuous flow).
//  - Accept when in_valid && in_ready: all outputs load decoded values at that edge, out_valid=1.
//    Latency 1 cycle input->output. No accept && out_ready && out_valid: out_valid->0 (data regs hold).
//  - Stall (out_valid && !out_ready): every output holds exactly; in_ready=0.
//  - flush=1: next edge out_valid=0; an input offered that cycle is dropped (in_ready still
//    reported, transfer counts as consumed). Flush has priority over accept.
//  - Decode, opcode=instr[31:26], funct=instr[5:0], imm=instr[15:0]:
//    R-type (opcode 0): input_a=rs_data, input_b=rt_data, dest_reg=instr[15:11];
//      funct 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT.
//    I-type: input_a=rs_data, dest_reg=instr[20:16]:
//      0x08 ADDI->ADD sign-ext; 0x09 ADDIU->ADDU sign-ext; 0x0A SLTI->SLT sign-ext;
//      0x0C ANDI->AND zero-ext; 0x0D ORI->OR zero-ext.
//    LUI 0x0F: input_a=0, input_b={imm,16'h0}, control=OR, dest_reg=instr[20:16].
//    Sign-ext = {{16{imm[15]}},imm}; zero-ext = {16'h0,imm}.
//  - reg_write=1 for supported ops with dest_reg!=0; dest_reg 0 issues with reg_write=0.
//  - Unsupported opcode/funct: issued (out_valid=1) with control=CONTROL_AND, operands as
//    decoded fields or 0, reg_write=0, err_unsupported=1; never blocks the pipe.
//  - No arithmetic performed here; overflow detection belongs to alu_32.
// TESTING
//  1 reset=1 two cycles with in_valid=1 -> all outputs 0, out_valid=0; reset mid-stall clears out_valid.
//  2 add $3,$1,$2 (0x00221820), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, a=5, b=7,
//    control=2, dest_reg=3, reg_write=1.
//  3 addi $4,$1,-1 (0x2024FFFF), rs=10 -> b=0xFFFFFFFF, control=2; ori $4,$1,0xFFFF -> b=0x0000FFFF, control=1.
//  4 lui $5,0x1234 -> a=0, b=0x12340000, control=1, dest_reg=5; same with $0 dest -> reg_write=0.
//  5 out_ready=0 for 3 cycles with new input offered -> in_ready=0, outputs held bit-exact;
//    out_ready=1 -> next op loads, back-to-back stream of 8 ops shows no bubbles/drops.
//  6 flush while stalled and input offered -> out_valid=0 next cycle, offered op never appears;
//    funct 0x18 (mult) -> err_unsupported=1, reg_write=0.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bus between the issue stage, its instruction source and alu_32.
// The master side is the environment (fetch/regfile upstream, alu_32 downstream); the slave side is the stage.
interface alu_issue_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] input_a;
   logic [31:0] input_b;
   logic [3:0]  control;
   logic [4:0]  dest_reg;
   logic        reg_write;
   logic        err_unsupported;

   modport master (
      output in_valid, instruction, rs_data, rt_data, out_ready,
      input  in_ready, out_valid, input_a, input_b, control, dest_reg, reg_write, err_unsupported
   );

   modport slave (
      input  in_valid, instruction, rs_data, rt_data, out_ready,
      output in_ready, out_valid, input_a, input_b, control, dest_reg, reg_write, err_unsupported
   );
endinterface

// File: rtl/alu_issue_stage.sv
// MIPS decode/issue stage feeding alu_32: decodes ALU control, selects operand B and holds
// the issued operation in a single-entry ID/EX register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
// in_ready = !out_valid || out_ready, so a held op leaving and a new op entering share one edge.
module alu_issue_stage #(
   parameter logic [3:0] CONTROL_AND  = 4'h0,
   parameter logic [3:0] CONTROL_OR   = 4'h1,
   parameter logic [3:0] CONTROL_ADD  = 4'h2,
   parameter logic [3:0] CONTROL_ADDU = 4'h3,
   parameter logic [3:0] CONTROL_SUB  = 4'h6,
   parameter logic [3:0] CONTROL_SLT  = 4'h7,
   parameter logic [3:0] CONTROL_SUBU = 4'h8,
   parameter logic [3:0] CONTROL_NOR  = 4'hC,
   parameter bit         ENABLE_LUI   = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   alu_issue_stage_if.slave   bus
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;

   assign opcode   = bus.instruction[31:26];
   assign funct    = bus.instruction[5:0];
   assign imm      = bus.instruction[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};

   // rs field and shamt are never needed: operands arrive already read from the register file.
   logic unused_fields;
   assign unused_fields = ^{bus.instruction[25:21], bus.instruction[10:6]};

   logic [31:0] dec_a;
   logic [31:0] dec_b;
   logic [3:0]  dec_ctrl;
   logic [4:0]  dec_dest;
   logic        dec_ok;

   always_comb begin
      dec_a    = bus.rs_data;
      dec_b    = bus.rt_data;
      dec_dest = bus.instruction[15:11];
      dec_ctrl = CONTROL_AND;
      dec_ok   = 1'b0;
      if (opcode == 6'h00) begin
         dec_ok = 1'b1;
         case (funct)
            6'h20:   dec_ctrl = CONTROL_ADD;
            6'h21:   dec_ctrl = CONTROL_ADDU;
            6'h22:   dec_ctrl = CONTROL_SUB;
            6'h23:   dec_ctrl = CONTROL_SUBU;
            6'h24:   dec_ctrl = CONTROL_AND;
            6'h25:   dec_ctrl = CONTROL_OR;
            6'h27:   dec_ctrl = CONTROL_NOR;
            6'h2A:   dec_ctrl = CONTROL_SLT;
            default: dec_ok   = 1'b0;
         endcase
      end else begin
         dec_dest = bus.instruction[20:16];
         case (opcode)
            6'h08: begin dec_ctrl = CONTROL_ADD;  dec_b = imm_sext; dec_ok = 1'b1; end
            6'h09: begin dec_ctrl = CONTROL_ADDU; dec_b = imm_sext; dec_ok = 1'b1; end
            6'h0A: begin dec_ctrl = CONTROL_SLT;  dec_b = imm_sext; dec_ok = 1'b1; end
            6'h0C: begin dec_ctrl = CONTROL_AND;  dec_b = imm_zext; dec_ok = 1'b1; end
            6'h0D: begin dec_ctrl = CONTROL_OR;   dec_b = imm_zext; dec_ok = 1'b1; end
            6'h0F: begin
               // LUI is issued as 0 | (imm << 16) so alu_32 needs no shifter path.
               if (ENABLE_LUI) begin
                  dec_a    = 32'h0;
                  dec_b    = {imm, 16'h0000};
                  dec_ctrl = CONTROL_OR;
                  dec_ok   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   logic        out_valid_q;
   logic [31:0] input_a_q;
   logic [31:0] input_b_q;
   logic [3:0]  control_q;
   logic [4:0]  dest_reg_q;
   logic        reg_write_q;
   logic        err_q;
   logic        accept;

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         input_a_q   <= 32'h0;
         input_b_q   <= 32'h0;
         control_q   <= 4'h0;
         dest_reg_q  <= 5'h0;
         reg_write_q <= 1'b0;
         err_q       <= 1'b0;
      end else if (flush) begin
         // Redirect: the offered op counts as consumed but is dropped; data regs keep old values.
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         input_a_q   <= dec_a;
         input_b_q   <= dec_b;
         control_q   <= dec_ctrl;
         dest_reg_q  <= dec_dest;
         reg_write_q <= dec_ok && (dec_dest != 5'h0);
         err_q       <= !dec_ok;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid       = out_valid_q;
   assign bus.input_a         = input_a_q;
   assign bus.input_b         = input_b_q;
   assign bus.control         = control_q;
   assign bus.dest_reg        = dest_reg_q;
   assign bus.reg_write       = reg_write_q;
   assign bus.err_unsupported = err_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus a randomized stream, all checked against
// a queue-based model of the single-entry register and a decode table built from the ISA rules.
module tb_alu_issue_stage;

   logic clock;
   logic reset;
   logic flush;
   alu_issue_stage_if bus ();

   alu_issue_stage dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;

   // Expected word: {a[74:43], b[42:11], ctrl[10:7], dest[6:2], reg_write[1], err[0]}
   logic [74:0] exp_q[$];

   function automatic logic [74:0] ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                              input logic [31:0] rt);
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  c;
      logic [4:0]  d;
      logic        ok;
      op = ins[31:26];
      fn = ins[5:0];
      imm = ins[15:0];
      a = rs;
      b = rt;
      c = 4'h0;
      ok = 1'b1;
      if (op == 6'd0) begin
         d = ins[15:11];
         if      (fn == 6'h20) c = 4'h2;
         else if (fn == 6'h21) c = 4'h3;
         else if (fn == 6'h22) c = 4'h6;
         else if (fn == 6'h23) c = 4'h8;
         else if (fn == 6'h24) c = 4'h0;
         else if (fn == 6'h25) c = 4'h1;
         else if (fn == 6'h27) c = 4'hC;
         else if (fn == 6'h2A) c = 4'h7;
         else ok = 1'b0;
      end else begin
         d = ins[20:16];
         if      (op == 6'h08) begin c = 4'h2; b = 32'(signed'(imm)); end
         else if (op == 6'h09) begin c = 4'h3; b = 32'(signed'(imm)); end
         else if (op == 6'h0A) begin c = 4'h7; b = 32'(signed'(imm)); end
         else if (op == 6'h0C) begin c = 4'h0; b = 32'(imm); end
         else if (op == 6'h0D) begin c = 4'h1; b = 32'(imm); end
         else if (op == 6'h0F) begin c = 4'h1; a = 32'h0; b = 32'(imm) << 16; end
         else ok = 1'b0;
      end
      if (!ok) c = 4'h0;
      return {a, b, c, d, ok && (d != 5'd0), !ok};
   endfunction

   function automatic logic [31:0] pick_instr();
      logic [5:0] functs [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
      logic [5:0] iops   [6] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 9))
         0, 1, 2, 3: w = {6'h00, w[25:6], functs[$urandom_range(0, 7)]};
         4, 5, 6, 7: w = {iops[$urandom_range(0, 5)], w[25:0]};
         8:          w = {6'h00, w[25:6], 6'h18};
         default:    ;
      endcase
      return w;
   endfunction

   // One clock of stimulus: apply inputs, check the registered outputs and in_ready against
   // the model, then advance the model across the rising edge.
   task automatic drive_cycle(input logic rst, input logic fl, input logic iv,
                              input logic [31:0] ins, input logic [31:0] rs,
                              input logic [31:0] rt, input logic ordy);
      logic        was_empty;
      logic        exp_ready;
      logic [74:0] got;
      logic [74:0] mask;
      reset           = rst;
      flush           = fl;
      bus.in_valid    = iv;
      bus.instruction = ins;
      bus.rs_data     = rs;
      bus.rt_data     = rt;
      bus.out_ready   = ordy;
      #1;
      was_empty = (exp_q.size() == 0);
      exp_ready = was_empty || ordy;
      n_cmp++;
      if (bus.in_ready !== exp_ready) begin
         n_fail++;
         $display("FAIL in_ready: got %b expected %b at %0t", bus.in_ready, exp_ready, $time);
      end
      n_cmp++;
      if (bus.out_valid !== !was_empty) begin
         n_fail++;
         $display("FAIL out_valid: got %b expected %b at %0t", bus.out_valid, !was_empty, $time);
      end
      if (!was_empty) begin
         got  = {bus.input_a, bus.input_b, bus.control, bus.dest_reg, bus.reg_write,
                 bus.err_unsupported};
         // Operands and dest of an unsupported op are don't-care.
         mask = exp_q[0][0] ? 75'h7_83 : '1;
         n_cmp++;
         if ((got & mask) !== (exp_q[0] & mask)) begin
            n_fail++;
            $display("FAIL issued_op: got %h expected %h at %0t", got, exp_q[0], $time);
         end
      end
      @(posedge clock);
      if (rst || fl) begin
         exp_q.delete();
      end else begin
         if (!was_empty && ordy) void'(exp_q.pop_front());
         if (iv && exp_ready) exp_q.push_back(ref_decode(ins, rs, rt));
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      flush = 1'b0;
      bus.in_valid = 1'b1;
      bus.instruction = 32'h00221820;
      bus.rs_data = 32'd5;
      bus.rt_data = 32'd7;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if ({bus.out_valid, bus.input_a, bus.input_b, bus.control, bus.dest_reg, bus.reg_write,
           bus.err_unsupported} !== 76'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b a=%h b=%h c=%h d=%0d rw=%b err=%b expected all 0",
                  bus.out_valid, bus.input_a, bus.input_b, bus.control, bus.dest_reg,
                  bus.reg_write, bus.err_unsupported);
      end
      exp_q.delete();
      // Reset while stalled with a held op.
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h00221820, 32'd1, 32'd2, 1'b1);
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b1, 32'h00221820, 32'd3, 32'd4, 1'b0);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_stall: out_valid got %b expected 0", bus.out_valid);
      end
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
   endtask

   task automatic test_add();
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h00221820, 32'd5, 32'd7, 1'b1);
      n_cmp++;
      if ({bus.out_valid, bus.input_a, bus.input_b, bus.control, bus.dest_reg, bus.reg_write} !==
          {1'b1, 32'd5, 32'd7, 4'd2, 5'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL add: got v=%b a=%0d b=%0d c=%0d d=%0d rw=%b expected 1/5/7/2/3/1",
                  bus.out_valid, bus.input_a, bus.input_b, bus.control, bus.dest_reg,
                  bus.reg_write);
      end
   endtask

   task automatic test_immediates();
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h2024FFFF, 32'd10, 32'd99, 1'b1);
      n_cmp++;
      if ({bus.input_a, bus.input_b, bus.control, bus.dest_reg} !==
          {32'd10, 32'hFFFF_FFFF, 4'd2, 5'd4}) begin
         n_fail++;
         $display("FAIL addi_sext: got a=%h b=%h c=%0d d=%0d expected a=0000000a b=ffffffff c=2 d=4",
                  bus.input_a, bus.input_b, bus.control, bus.dest_reg);
      end
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h3424FFFF, 32'd10, 32'd99, 1'b1);
      n_cmp++;
      if ({bus.input_b, bus.control} !== {32'h0000_FFFF, 4'd1}) begin
         n_fail++;
         $display("FAIL ori_zext: got b=%h c=%0d expected b=0000ffff c=1", bus.input_b,
                  bus.control);
      end
   endtask

   task automatic test_lui();
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h3C051234, 32'hDEAD_BEEF, 32'h1, 1'b1);
      n_cmp++;
      if ({bus.input_a, bus.input_b, bus.control, bus.dest_reg, bus.reg_write} !==
          {32'h0, 32'h1234_0000, 4'd1, 5'd5, 1'b1}) begin
         n_fail++;
         $display("FAIL lui: got a=%h b=%h c=%0d d=%0d rw=%b expected 0/12340000/1/5/1",
                  bus.input_a, bus.input_b, bus.control, bus.dest_reg, bus.reg_write);
      end
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h3C001234, 32'h0, 32'h0, 1'b1);
      n_cmp++;
      if ({bus.out_valid, bus.dest_reg, bus.reg_write, bus.err_unsupported} !==
          {1'b1, 5'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL lui_r0: got v=%b d=%0d rw=%b err=%b expected 1/0/0/0", bus.out_valid,
                  bus.dest_reg, bus.reg_write, bus.err_unsupported);
      end
   endtask

   task automatic test_stall_back_to_back();
      logic [75:0] snap;
      int ready_cnt;
      int valid_cnt;
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h00853022, 32'd100, 32'd40, 1'b1);
      snap = {bus.out_valid, bus.input_a, bus.input_b, bus.control, bus.dest_reg, bus.reg_write,
              bus.err_unsupported};
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b0, 1'b1, 32'h00A63825, 32'd1, 32'd2, 1'b0);
         n_cmp++;
         if ({bus.out_valid, bus.input_a, bus.input_b, bus.control, bus.dest_reg, bus.reg_write,
              bus.err_unsupported} !== snap) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: outputs changed, got v=%b a=%h b=%h expected %h", i,
                     bus.out_valid, bus.input_a, bus.input_b, snap);
         end
      end
      ready_cnt = 0;
      valid_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b0, 1'b0, 1'b1, pick_instr(), $urandom, $urandom, 1'b1);
         if (bus.out_valid === 1'b1) valid_cnt++;
         #1;
         if (bus.in_ready === 1'b1) ready_cnt++;
      end
      n_cmp++;
      if (valid_cnt != 8 || ready_cnt != 8) begin
         n_fail++;
         $display("FAIL back_to_back: valid cycles %0d ready cycles %0d expected 8 and 8",
                  valid_cnt, ready_cnt);
      end
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
   endtask

   task automatic test_flush_unsupported();
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h00221820, 32'd8, 32'd9, 1'b1);
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      drive_cycle(1'b0, 1'b1, 1'b1, 32'h20E7_0055, 32'd3, 32'd0, 1'b0);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush: out_valid got %b expected 0", bus.out_valid);
      end
      repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h00221818, 32'd4, 32'd6, 1'b1);
      n_cmp++;
      if ({bus.out_valid, bus.control, bus.reg_write, bus.err_unsupported} !==
          {1'b1, 4'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL mult_unsupported: got v=%b c=%0d rw=%b err=%b expected 1/0/0/1",
                  bus.out_valid, bus.control, bus.reg_write, bus.err_unsupported);
      end
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive_cycle(1'b0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                     pick_instr(), $urandom, $urandom, ($urandom_range(0, 3) != 0));
      end
      repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_add();
      test_immediates();
      test_lui();
      test_stall_back_to_back();
      test_flush_unsupported();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
